// File: rtl/rv32i_mem_arbiter.sv
// Fetch/data arbiter in front of one single-port memory, one transaction in flight.
// Optional wait-cycle statistics are built only when RV32I_MEM_ARB_STATS_EN is defined.
module rv32i_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_re_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_be_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] if_wait_cnt_o,
  output logic [31:0] dm_wait_cnt_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // state  | meaning
  // S_IDLE | sample requests, grant one, latch its fields
  // S_REQ  | present latched request until mem_ready_i
  // S_WAIT | read accepted, wait for mem_rvalid_i
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        state_q;
  logic [SW-1:0] starve_q;
  logic          owner_dm_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;

  logic dm_any, force_if, pick_dm, pick_if, in_idle;
  logic store_done, rd_done;

  assign dm_any   = dm_re_i | dm_we_i;
  assign force_if = if_req_i && (starve_q == STARVE_MAX);
  assign pick_dm  = dm_any && !force_if;
  assign pick_if  = if_req_i && !pick_dm;

  // Outputs are gated by resetn_i so nothing leaks while reset is held low.
  assign in_idle  = resetn_i && (state_q == S_IDLE);
  assign dm_gnt_o = in_idle && pick_dm;
  assign if_gnt_o = in_idle && pick_if;

  assign mem_req_o   = resetn_i && (state_q == S_REQ);
  assign mem_we_o    = mem_req_o && we_q;
  assign mem_addr_o  = mem_req_o ? addr_q  : 32'h0;
  assign mem_wdata_o = mem_req_o ? wdata_q : 32'h0;
  assign mem_be_o    = mem_req_o ? be_q    : 4'h0;

  assign store_done = mem_req_o && mem_ready_i && we_q;
  assign rd_done    = resetn_i && (state_q == S_WAIT) && mem_rvalid_i;

  assign dm_rvalid_o = store_done || (rd_done && owner_dm_q);
  assign if_rvalid_o = rd_done && !owner_dm_q;
  assign dm_rdata_o  = (rd_done && owner_dm_q) ? mem_rdata_i : 32'h0;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;

  assign stall_o = (if_req_i | dm_any) & ~(if_rvalid_o | dm_rvalid_o);

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      starve_q   <= '0;
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_dm) begin
            owner_dm_q <= 1'b1;
            we_q       <= dm_we_i;
            addr_q     <= dm_addr_i;
            wdata_q    <= dm_wdata_i;
            be_q       <= dm_be_i;
            if (if_req_i && starve_q != STARVE_MAX)
              starve_q <= starve_q + SW'(1);
            state_q    <= S_REQ;
          end else if (pick_if) begin
            owner_dm_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= if_addr_i;
            wdata_q    <= 32'h0;
            be_q       <= 4'hF;
            starve_q   <= '0;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready_i)
            state_q <= we_q ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid_i)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef RV32I_MEM_ARB_STATS_EN
  logic [31:0] if_wait_q, dm_wait_q;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      if_wait_q <= 32'h0;
      dm_wait_q <= 32'h0;
    end else begin
      if (if_req_i && !if_rvalid_o) if_wait_q <= if_wait_q + 32'h1;
      if (dm_any && !dm_rvalid_o)   dm_wait_q <= dm_wait_q + 32'h1;
    end
  end

  assign if_wait_cnt_o = if_wait_q;
  assign dm_wait_cnt_o = dm_wait_q;
`else
  assign if_wait_cnt_o = 32'h0;
  assign dm_wait_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter: directed scenarios push expected responses,
// a negedge monitor pops and compares them whenever an rvalid appears.
module tb_rv32i_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_re_i, dm_we_i;
  logic [31:0] dm_addr_i, dm_wdata_i;
  logic [3:0]  dm_be_i;
  logic        dm_gnt_o, dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ready_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [31:0] if_wait_cnt_o, dm_wait_cnt_o;

`ifdef RV32I_MEM_ARB_STATS_EN
  localparam logic [31:0] EXP_DM_WAIT = 32'd4;
`else
  localparam logic [31:0] EXP_DM_WAIT = 32'd0;
`endif

  always #5 clk_i = ~clk_i;

  rv32i_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_re_i(dm_re_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i),
    .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o),
    .if_wait_cnt_o(if_wait_cnt_o), .dm_wait_cnt_o(dm_wait_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        is_dm;
    logic [31:0] data;
  } resp_t;
  resp_t exp_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void push(logic is_dm, logic [31:0] data);
    resp_t r;
    r.is_dm = is_dm;
    r.data  = data;
    exp_q.push_back(r);
  endfunction

  // Memory model: ready after ready_delay REQ cycles; read data = addr ^ 0xCAFE0000,
  // returned rvalid_delay cycles after the cycle following acceptance.
  int          ready_delay = 0;
  int          rvalid_delay = 0;
  int          rcnt = 0;
  int          wcnt = 0;
  bit          in_wait = 0;
  logic [31:0] pdata = 32'h0;

  always begin
    @(posedge clk_i);
    #2;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    if (in_wait) begin
      if (wcnt >= rvalid_delay) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = pdata;
        in_wait      = 0;
      end else wcnt++;
    end
    mem_ready_i = 1'b0;
    if (mem_req_o) begin
      if (rcnt >= ready_delay) begin
        mem_ready_i = 1'b1;
        rcnt = 0;
        if (!mem_we_o) begin
          in_wait = 1;
          wcnt    = 0;
          pdata   = mem_addr_o ^ 32'hCAFE_0000;
        end
      end else rcnt++;
    end else rcnt = 0;
  end

  always @(negedge clk_i) begin
    if (if_rvalid_o || dm_rvalid_o) begin
      resp_t e;
      if (exp_q.size() == 0) check("unexpected_rvalid", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("resp_port", {31'b0, dm_rvalid_o}, {31'b0, e.is_dm});
        check("resp_both", {31'b0, if_rvalid_o & dm_rvalid_o}, 32'd0);
        check("resp_data", dm_rvalid_o ? dm_rdata_o : if_rdata_o, e.data);
        check("other_rdata", dm_rvalid_o ? if_rdata_o : dm_rdata_o, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic wait_resp(input logic is_dm);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_i);
      seen = is_dm ? dm_rvalid_o : if_rvalid_o;
    end
    if (!seen) check("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic exp_dm;
    resetn_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h100;
    dm_re_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0; dm_be_i = 4'h0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;

    // reset held with a pending fetch
    step(); step(); sample();
    check("rst_if_gnt", {31'b0, if_gnt_o}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_mem_be", {28'b0, mem_be_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_stall", {31'b0, stall_o}, 32'd1);
    step(); resetn_i = 1'b1; if_req_i = 1'b0; sample();
    check("idle_stall", {31'b0, stall_o}, 32'd0);

    // fetch only, zero-wait memory
    step(); if_req_i = 1'b1; if_addr_i = 32'h100; sample();
    check("f_gnt_c0", {31'b0, if_gnt_o}, 32'd1);
    check("f_memreq_c0", {31'b0, mem_req_o}, 32'd0);
    push(1'b0, 32'hCAFE_0100);
    step(); sample();
    check("f_gnt_c1", {31'b0, if_gnt_o}, 32'd0);
    check("f_memreq_c1", {31'b0, mem_req_o}, 32'd1);
    check("f_addr_c1", mem_addr_o, 32'h100);
    check("f_be_c1", {28'b0, mem_be_o}, 32'hF);
    check("f_we_c1", {31'b0, mem_we_o}, 32'd0);
    step(); sample();
    check("f_rvalid_c2", {31'b0, if_rvalid_o}, 32'd1);
    check("f_stall_c2", {31'b0, stall_o}, 32'd0);

    // simultaneous fetch and load: data first
    step(); if_req_i = 1'b1; if_addr_i = 32'h200; dm_re_i = 1'b1; dm_addr_i = 32'h2000; sample();
    check("sim_dm_gnt", {31'b0, dm_gnt_o}, 32'd1);
    check("sim_if_gnt", {31'b0, if_gnt_o}, 32'd0);
    push(1'b1, 32'hCAFE_2000);
    step(); sample();
    check("sim_stall_req", {31'b0, stall_o}, 32'd1);
    check("sim_addr", mem_addr_o, 32'h2000);
    wait_resp(1'b1);
    check("sim_stall_rv", {31'b0, stall_o}, 32'd0);
    step(); dm_re_i = 1'b0; sample();
    check("sim_if_gnt2", {31'b0, if_gnt_o}, 32'd1);
    check("sim_stall_if", {31'b0, stall_o}, 32'd1);
    push(1'b0, 32'hCAFE_0200);
    wait_resp(1'b0);
    step(); if_req_i = 1'b0;

    // starvation: four data grants, then fetch forced, then data again
    if_req_i = 1'b1; if_addr_i = 32'h104; dm_re_i = 1'b1; dm_addr_i = 32'h3000;
    for (int k = 0; k < 6; k++) begin
      sample();
      exp_dm = (k != 4);
      check($sformatf("starve_dm_gnt%0d", k), {31'b0, dm_gnt_o}, {31'b0, exp_dm});
      check($sformatf("starve_if_gnt%0d", k), {31'b0, if_gnt_o}, {31'b0, !exp_dm});
      push(exp_dm, (exp_dm ? dm_addr_i : if_addr_i) ^ 32'hCAFE_0000);
      wait_resp(exp_dm);
      step();
      if (exp_dm) dm_addr_i = dm_addr_i + 32'd4;
      else        if_addr_i = if_addr_i + 32'd4;
    end
    if_req_i = 1'b0; dm_re_i = 1'b0;

    // reset while waiting for read data; late rvalid lands in IDLE
    rvalid_delay = 3;
    step(); if_req_i = 1'b1; if_addr_i = 32'h500; sample();
    check("rw_gnt", {31'b0, if_gnt_o}, 32'd1);
    step(); sample();
    check("rw_memreq", {31'b0, mem_req_o}, 32'd1);
    step(); sample();
    check("rw_wait_req", {31'b0, mem_req_o}, 32'd0);
    step(); resetn_i = 1'b0; sample();
    check("rw_rst_gnt", {31'b0, if_gnt_o}, 32'd0);
    check("rw_rst_rvalid", {31'b0, if_rvalid_o}, 32'd0);
    check("rw_rst_stall", {31'b0, stall_o}, 32'd1);
    step(); resetn_i = 1'b1; if_req_i = 1'b0; sample();
    check("rw_idle_req", {31'b0, mem_req_o}, 32'd0);
    step(); sample();
    check("rw_late_if_rv", {31'b0, if_rvalid_o}, 32'd0);
    check("rw_late_dm_rv", {31'b0, dm_rvalid_o}, 32'd0);
    check("rw_late_req", {31'b0, mem_req_o}, 32'd0);
    check("rw_if_cnt", if_wait_cnt_o, 32'd0);
    check("rw_dm_cnt", dm_wait_cnt_o, 32'd0);
    rvalid_delay = 0;

    // store (re+we together) with memory not ready for 3 cycles
    ready_delay = 3;
    step(); dm_we_i = 1'b1; dm_re_i = 1'b1; dm_addr_i = 32'h40;
    dm_wdata_i = 32'hDEAD_BEEF; dm_be_i = 4'b0011; sample();
    check("st_gnt", {31'b0, dm_gnt_o}, 32'd1);
    push(1'b1, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      step(); sample();
      check($sformatf("st_req%0d", c), {31'b0, mem_req_o}, 32'd1);
      check($sformatf("st_we%0d", c), {31'b0, mem_we_o}, 32'd1);
      check($sformatf("st_addr%0d", c), mem_addr_o, 32'h40);
      check($sformatf("st_wdata%0d", c), mem_wdata_o, 32'hDEAD_BEEF);
      check($sformatf("st_be%0d", c), {28'b0, mem_be_o}, 32'h3);
      check($sformatf("st_rvalid%0d", c), {31'b0, dm_rvalid_o}, {31'b0, c == 4});
    end
    step(); dm_we_i = 1'b0; dm_re_i = 1'b0; sample();
    check("st_done_req", {31'b0, mem_req_o}, 32'd0);
    check("st_dm_cnt", dm_wait_cnt_o, EXP_DM_WAIT);
    check("st_if_cnt", if_wait_cnt_o, 32'd0);
    ready_delay = 0;

    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_arbiter.md
RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL be the number of consecutive data-port grants allowed while fetch waits before fetch is forced to win.
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 resetn_i  in  1  reset, SHALL be synchronous and active-low.
REQ-004 if_req_i  in  1  fetch request; if_addr_i  in  32  fetch address.
REQ-005 if_gnt_o  out  1  fetch accepted; if_rvalid_o  out  1  fetch data valid; if_rdata_o  out  32  fetch data.
REQ-006 dm_re_i  in  1  load request; dm_we_i  in  1  store request; dm_addr_i  in  32; dm_wdata_i  in  32; dm_be_i  in  4  byte enables.
REQ-007 dm_gnt_o  out  1  data accepted; dm_rvalid_o  out  1  load data valid or store done; dm_rdata_o  out  32  load data.
REQ-008 mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  32; mem_wdata_o  out  32; mem_be_o  out  4  shared single-port memory request.
REQ-009 mem_ready_i  in  1  memory accepts request; mem_rvalid_i  in  1  read data valid; mem_rdata_i  in  32.
REQ-010 stall_o  out  1  pipeline hold request.
REQ-011 if_wait_cnt_o  out  32, dm_wait_cnt_o  out  32  wait-cycle counters (see Configuration).

Function
REQ-012 FSM states SHALL be IDLE, REQ, WAIT; one outstanding memory transaction maximum.
REQ-013 Requests SHALL be sampled only in IDLE; requesters hold req/address/data stable until their rvalid pulse and deassert the cycle after unless issuing a new access.
REQ-014 IDLE arbitration: data request (dm_re_i|dm_we_i) wins unless if_req_i=1 and starve_cnt==STARVE_LIMIT; otherwise fetch wins if if_req_i=1.
REQ-015 Winner's gnt SHALL pulse for exactly the IDLE cycle of selection; address, wdata, be, we and owner latched; next state REQ.
REQ-016 dm_we_i=1 with dm_re_i=1 SHALL be treated as a store.
REQ-017 REQ: mem_req_o=1 with latched fields, held stable until mem_ready_i=1; mem_we_o=1 only for stores, mem_be_o=4'hF for fetch.
REQ-018 REQ with mem_ready_i=1: store SHALL pulse dm_rvalid_o that cycle and return to IDLE; read SHALL go to WAIT.
REQ-019 WAIT: on mem_rvalid_i=1, mem_rdata_i SHALL pass combinationally to owner's rdata with owner's rvalid pulsed that cycle; next state IDLE.
REQ-020 Minimum latency: read 3 cycles gnt-to-rvalid inclusive with zero-wait memory; store 2 cycles.
REQ-021 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment, saturating at STARVE_LIMIT, on each data grant with if_req_i=1; clear to 0 on every fetch grant.
REQ-022 stall_o SHALL equal (if_req_i|dm_re_i|dm_we_i) & ~(if_rvalid_o|dm_rvalid_o).
REQ-023 mem_rvalid_i in IDLE or REQ SHALL be ignored; no rvalid output generated.
REQ-024 Non-owner rvalid SHALL remain 0; rdata outputs SHALL be 0 when respective rvalid=0.

Reset
REQ-025 resetn_i=0 at a clock edge SHALL force IDLE, starve_cnt=0, counters=0, latched fields=0, independent of current state.
REQ-026 During and after reset: all gnt, rvalid, mem_req_o, mem_we_o = 0, mem_addr_o/mem_wdata_o = 0, mem_be_o = 0; stall_o follows REQ-022.
REQ-027 Reset mid-transaction SHALL abandon it; no rvalid issued for it.

Configuration
REQ-028 Macro RV32I_MEM_ARB_STATS_EN defined: if_wait_cnt_o/dm_wait_cnt_o SHALL count cycles with that port's request high and its rvalid low, wrapping at 2^32.
REQ-029 Macro undefined: counters SHALL not be built and both outputs tied to 32'h0; all other behaviour identical.

Verification
REQ-030 Fetch only, addr 0x100, mem_ready_i and mem_rvalid_i same-cycle-ready -> if_gnt_o cycle 0, mem_req_o cycle 1, if_rvalid_o cycle 2 with mem_rdata_i value.
REQ-031 Simultaneous if_req_i and dm_re_i addr 0x2000 -> dm_gnt_o first, fetch served next IDLE; stall_o high until respective rvalid.
REQ-032 dm requests continuous with fetch pending, STARVE_LIMIT=4 -> 4 data grants then if_gnt_o, starve_cnt back to 0.
REQ-033 Store 0xDEADBEEF be 4'b0011, mem_ready_i low 3 cycles -> mem_req_o/fields stable 4 cycles, dm_rvalid_o on accept cycle.
REQ-034 resetn_i low during WAIT, then mem_rvalid_i=1 -> state IDLE, no rvalid pulse, mem_req_o=0.
REQ-035 RV32I_MEM_ARB_STATS_EN defined, scenario REQ-033 -> dm_wait_cnt_o=4; undefined -> 0.
